// File: rtl/sig_debounce_pkg.sv
// Shared definitions for input-conditioning blocks: debounce FSM state encodings
// and small helpers used by the debouncer.
package sig_debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE_LO = 2'b00,
      ST_WAIT_HI = 2'b01,
      ST_IDLE_HI = 2'b10,
      ST_WAIT_LO = 2'b11
   } state_e;

   // Settled state that corresponds to a given accepted level.
   function automatic state_e idle_state(input logic level);
      return level ? ST_IDLE_HI : ST_IDLE_LO;
   endfunction

   function automatic logic is_wait(input state_e st);
      return (st == ST_WAIT_HI) || (st == ST_WAIT_LO);
   endfunction

endpackage

// File: rtl/sig_debounce_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; the last stage is the
// only one safe to use in the clk domain.
module sig_synchronizer #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= {STAGES{RESET_LEVEL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Debouncer: synchronizes a raw input, then accepts a level change only after it
// has been stable for DEBOUNCE_CYCLES consecutive synchronized cycles.
module sig_debounce
   import sig_debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter int   GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sig_in,
   output logic                sig_out,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int                  CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   logic sig_sync;

   sig_synchronizer #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sig_in),
      .q   (sig_sync)
   );

   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [GLITCH_W-1:0] glitch_q,  glitch_d;
   logic                sig_out_q, sig_out_d;
   logic [GLITCH_W-1:0] glitch_inc;

   always_comb begin
      glitch_inc = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_W'(1);
   end

   // The entry into WAIT already counts as the first stable cycle, so cnt starts at 1.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      glitch_d  = glitch_q;
      sig_out_d = sig_out_q;
      case (state_q)
         ST_IDLE_LO: begin
            if (sig_sync) begin
               state_d = ST_WAIT_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!sig_sync) begin
               state_d  = ST_IDLE_LO;
               cnt_d    = '0;
               glitch_d = glitch_inc;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE_HI;
               sig_out_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_IDLE_HI: begin
            if (!sig_sync) begin
               state_d = ST_WAIT_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_WAIT_LO: begin
            if (sig_sync) begin
               state_d  = ST_IDLE_HI;
               cnt_d    = '0;
               glitch_d = glitch_inc;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE_LO;
               sig_out_d = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d   = ST_IDLE_LO;
            sig_out_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= idle_state(RESET_LEVEL);
         cnt_q     <= '0;
         glitch_q  <= '0;
         sig_out_q <= RESET_LEVEL;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         glitch_q  <= glitch_d;
         sig_out_q <= sig_out_d;
      end
   end

   assign sig_out    = sig_out_q;
   assign busy       = is_wait(state_q);
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sig_debounce.sv
// Directed bench for sig_debounce: expected sig_out edges (level + cycle) are queued
// by the stimulus and matched by an independent monitor on every observed toggle.
module tb_sig_debounce;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LAT  = SYNC + DEB;
   localparam int EW   = 33;

   logic       clk = 1'b0;
   logic       rst;
   logic       sig_in;
   logic       sig_out;
   logic       busy;
   logic [7:0] glitch_cnt;

   sig_debounce #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .RESET_LEVEL     (1'b0),
      .GLITCH_W        (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .sig_out    (sig_out),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   // Clock and cycle counter (cyc = number of posedges so far).
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic          mon_en   = 1'b0;
   logic          prev_out = 1'b0;
   int            pe_cnt   = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Expected sig_out edge for a level driven at the current negedge.
   task automatic push_edge(input logic lvl);
      logic [31:0] at;
      at = 32'(cyc + LAT);
      exp_q.push_back({lvl, at});
   endtask

   task automatic hold(input logic v, input int n);
      sig_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic qualify(input logic v, output int busy_n, output int first_busy);
      int c0;
      c0         = cyc;
      sig_in     = v;
      push_edge(v);
      busy_n     = 0;
      first_busy = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) begin
            busy_n++;
            if (first_busy < 0) first_busy = cyc - c0;
         end
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: every sig_out toggle must match the head of the expected queue.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (mon_en) begin
         if (sig_out !== prev_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_toggle: got level=%0b at cycle=%0d expected no edge",
                        sig_out, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e != {sig_out, 32'(cyc)}) begin
                  n_fail++;
                  $display("FAIL edge: got level=%0b cycle=%0d expected level=%0b cycle=%0d",
                           sig_out, cyc, e[32], e[31:0]);
               end
            end
            if (sig_out && !prev_out) pe_cnt++;
         end
         prev_out = sig_out;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   int b, f;
   int bounce[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

   initial begin
      rst    = 1'b1;
      sig_in = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_sig_out", int'(sig_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_glitch", int'(glitch_cnt), 0);
      rst      = 1'b0;
      prev_out = sig_out;
      mon_en   = 1'b1;
      @(negedge clk);

      // 1: clean rise
      qualify(1'b1, b, f);
      check("t1_busy_cycles", b, 3);
      check("t1_busy_start", f, 3);
      check("t1_sig_out", int'(sig_out), 1);
      check("t1_glitch", int'(glitch_cnt), 0);
      qualify(1'b0, b, f);

      // 2: three-cycle glitch
      hold(1'b1, 3);
      hold(1'b0, 8);
      check("t2_sig_out", int'(sig_out), 0);
      check("t2_glitch", int'(glitch_cnt), 1);
      check("t2_busy", int'(busy), 0);

      // 3: bounce train then held high
      pulse_rst();
      check("t3_glitch_after_rst", int'(glitch_cnt), 0);
      for (int i = 0; i < 9; i++) begin
         if (i == 5) push_edge(1'b1);
         hold(bounce[i] != 0, 1);
      end
      hold(1'b1, 6);
      check("t3_sig_out", int'(sig_out), 1);
      check("t3_glitch", int'(glitch_cnt), 2);

      // 4: clean fall
      qualify(1'b0, b, f);
      check("t4_busy_cycles", b, 3);
      check("t4_busy_start", f, 3);
      check("t4_sig_out", int'(sig_out), 0);
      check("t4_glitch", int'(glitch_cnt), 2);

      // 5: reset while WAIT_HI with cnt=2
      hold(1'b1, 4);
      check("t5_busy_pre", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_sig_out_rst", int'(sig_out), 0);
      check("t5_busy_rst", int'(busy), 0);
      check("t5_glitch_rst", int'(glitch_cnt), 0);
      rst = 1'b0;
      push_edge(1'b1);
      repeat (10) @(negedge clk);
      check("t5_sig_out_requal", int'(sig_out), 1);

      // 6: saturation then clean presses into an edge detector
      qualify(1'b0, b, f);
      for (int g = 1; g <= 300; g++) begin
         hold(1'b1, 2);
         hold(1'b0, 2);
         if (g == 100 || g == 255) begin
            repeat (3) @(negedge clk);
            check("t6_glitch_partial", int'(glitch_cnt), g);
         end
      end
      repeat (3) @(negedge clk);
      check("t6_glitch_sat", int'(glitch_cnt), 255);
      check("t6_sig_out_low", int'(sig_out), 0);
      pe_cnt = 0;
      for (int p = 0; p < 5; p++) begin
         qualify(1'b1, b, f);
         qualify(1'b0, b, f);
      end
      check("t6_pe_pulses", pe_cnt, 5);
      check("t6_glitch_hold", int'(glitch_cnt), 255);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_edges", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
